// File: rtl/mod6_down_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod6_down_counter_pkg
//   Shared timer-digit definitions. The mod-6 tens-of-seconds counter, the
//   mod-10 seconds counter and the minutes counter all use these constants,
//   plus a common clamp for parallel-load values.
// -----------------------------------------------------------------------------
package mod6_down_counter_pkg;

    localparam int unsigned DIGIT_WIDTH = 4;

    localparam logic [DIGIT_WIDTH-1:0] DIGIT_ZERO = 4'd0;
    localparam logic [DIGIT_WIDTH-1:0] MOD6_MAX   = 4'd5;

    // Clamp a load value so a digit never holds a value above its modulus.
    function automatic logic [DIGIT_WIDTH-1:0] sat_load(
        input logic [DIGIT_WIDTH-1:0] value,
        input logic [DIGIT_WIDTH-1:0] max_val
    );
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/mod6_down_counter_if.sv
// -----------------------------------------------------------------------------
// mod6_down_counter_if
//   Control/data bundle of one timer digit.
//     load         : async active-low parallel load of numero
//     enab         : count enable, active-high
//     numero       : parallel load value
//     numero_saida : current digit value
//     tc_saida     : terminal count (enab && digit == 0), cascades to next digit
//     zero_saida   : digit == 0
//   master = the timer controller driving the digit, slave = the digit itself.
// -----------------------------------------------------------------------------
interface mod6_down_counter_if
    import mod6_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DIGIT_WIDTH
);
    logic             load;
    logic             enab;
    logic [WIDTH-1:0] numero;
    logic [WIDTH-1:0] numero_saida;
    logic             tc_saida;
    logic             zero_saida;

    modport master (
        output load, enab, numero,
        input  numero_saida, tc_saida, zero_saida
    );

    modport slave (
        input  load, enab, numero,
        output numero_saida, tc_saida, zero_saida
    );
endinterface

// File: rtl/mod6_down_counter.sv
// -----------------------------------------------------------------------------
// mod6_down_counter
//   Modulo-6 BCD down-counter (5..0) for the tens-of-seconds timer digit.
//   Ports:
//     clk   : counter decrements on the rising edge when enabled
//     clear : async active-low clear, forces the digit to 0
//     bus   : slave side of mod6_down_counter_if (load, enab, numero in;
//             numero_saida, tc_saida, zero_saida out)
//   Priority: clear, then load, then enabled count, then hold.
// -----------------------------------------------------------------------------
module mod6_down_counter
    import mod6_down_counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = DIGIT_WIDTH,
    parameter logic [WIDTH-1:0] MAX_VAL = MOD6_MAX
) (
    input  logic               clk,
    input  logic               clear,
    mod6_down_counter_if.slave bus
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count_eff;

    assign load_val = sat_load(bus.numero, MAX_VAL);

    // Clocked next value: decrement with wrap 0 -> MAX_VAL, else hold.
    always_comb begin
        count_d = count_q;
        if (bus.enab) begin
            count_d = (count_q == DIGIT_ZERO) ? MAX_VAL : count_q - 1'b1;
        end
    end

    // The register captures the load value asynchronously when load falls and
    // keeps recapturing it on every clock edge while load stays low, so the
    // first edge after load is released starts counting from the loaded value.
    // NOTE: clear is the async reset of the count register, and every branch
    // uses non-blocking assignment so all readers see the pre-edge value.
    always_ff @(posedge clk or negedge clear or negedge bus.load) begin
        if (!clear) begin
            count_q <= DIGIT_ZERO;
        end else if (!bus.load) begin
            count_q <= load_val;
        end else begin
            count_q <= count_d;
        end
    end

    // The visible count follows clear and load as levels: while load is low
    // the digit tracks numero live, even between clock edges and after clear
    // is released without a new load edge.
    always_comb begin
        count_eff = count_q;
        if (!clear) begin
            count_eff = DIGIT_ZERO;
        end else if (!bus.load) begin
            count_eff = load_val;
        end
    end

    assign bus.numero_saida = count_eff;
    assign bus.zero_saida   = (count_eff == DIGIT_ZERO);
    assign bus.tc_saida     = bus.enab && (count_eff == DIGIT_ZERO);

endmodule

// File: tb/tb_mod6_down_counter.sv
// -----------------------------------------------------------------------------
// tb_mod6_down_counter
//   Directed bench for the mod-6 down-counter. Stimulus pushes hand-computed
//   expectations into a scoreboard queue and strobes the monitor, which pops
//   and compares the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mod6_down_counter;
    import mod6_down_counter_pkg::*;

    typedef struct {
        string      name;
        logic [3:0] count;
        logic       zero;
        logic       tc;
    } exp_t;

    logic clk;
    logic clear;

    mod6_down_counter_if #(.WIDTH(4)) bus ();

    mod6_down_counter #(.WIDTH(4), .MAX_VAL(4'd5)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    exp_t scb_q[$];
    event sample_ev;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // One full clock period; ends with clk low so sampling is away from the edge.
    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    // Queue an expectation for the current DUT state and let the monitor sample.
    task automatic expect_now(input string name, input logic [3:0] cnt,
                              input logic zero, input logic tc);
        exp_t e;
        e.name  = name;
        e.count = cnt;
        e.zero  = zero;
        e.tc    = tc;
        scb_q.push_back(e);
        -> sample_ev;
        #2;
    endtask

    // Monitor: pops the oldest expectation and compares on each strobe.
    initial begin
        forever begin
            @(sample_ev);
            #1;
            if (scb_q.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                exp_t e;
                e = scb_q.pop_front();
                check({e.name, ".count"}, int'(bus.numero_saida), int'(e.count));
                check({e.name, ".zero"},  int'(bus.zero_saida),   int'(e.zero));
                check({e.name, ".tc"},    int'(bus.tc_saida),     int'(e.tc));
            end
        end
    end

    initial begin
        logic [3:0] seq [7];
        seq = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5};

        clk        = 1'b0;
        clear      = 1'b0;
        bus.load   = 1'b1;
        bus.enab   = 1'b0;
        bus.numero = 4'd0;
        #3;
        expect_now("reset", 4'd0, 1'b1, 1'b0);
        bus.enab = 1'b1;
        expect_now("reset_tc_follows_enab", 4'd0, 1'b1, 1'b1);

        // 1. Clear released, count 7 edges: 5,4,3,2,1,0,5.
        clear = 1'b1;
        #1;
        for (int i = 0; i < 7; i++) begin
            tick();
            expect_now($sformatf("count_step%0d", i), seq[i],
                       seq[i] == 4'd0, seq[i] == 4'd0);
        end

        // 2. Async clear mid-count with clk idle.
        tick();
        tick();
        expect_now("at_three", 4'd3, 1'b0, 1'b0);
        clear = 1'b0;
        expect_now("async_clear", 4'd0, 1'b1, 1'b1);
        clear = 1'b1;
        expect_now("clear_released", 4'd0, 1'b1, 1'b1);

        // 3. Async load of 3, numero ignored once load is high, count to 0.
        bus.numero = 4'd3;
        bus.load   = 1'b0;
        expect_now("async_load3", 4'd3, 1'b0, 1'b0);
        bus.load = 1'b1;
        #1;
        bus.numero = 4'd4;
        expect_now("numero_ignored", 4'd3, 1'b0, 1'b0);
        tick();
        expect_now("load_cnt2", 4'd2, 1'b0, 1'b0);
        tick();
        expect_now("load_cnt1", 4'd1, 1'b0, 1'b0);
        tick();
        expect_now("load_cnt0_tc", 4'd0, 1'b1, 1'b1);

        // 4. Enable gating at zero.
        bus.enab = 1'b0;
        expect_now("enab_off", 4'd0, 1'b1, 1'b0);
        tick();
        expect_now("hold_edge1", 4'd0, 1'b1, 1'b0);
        tick();
        expect_now("hold_edge2", 4'd0, 1'b1, 1'b0);

        // 5. Out-of-range load saturates; load follows numero live.
        bus.numero = 4'd9;
        bus.load   = 1'b0;
        expect_now("load9_sat", 4'd5, 1'b0, 1'b0);
        bus.numero = 4'd1;
        expect_now("load_follows1", 4'd1, 1'b0, 1'b0);
        bus.numero = 4'd15;
        expect_now("load15_sat", 4'd5, 1'b0, 1'b0);
        tick();
        expect_now("load_low_edge", 4'd5, 1'b0, 1'b0);
        bus.load = 1'b1;
        bus.enab = 1'b1;
        #1;
        tick();
        expect_now("sat_then_count", 4'd4, 1'b0, 1'b0);

        // 6. Clear beats load; releasing clear exposes the load value.
        bus.numero = 4'd4;
        clear      = 1'b0;
        bus.load   = 1'b0;
        expect_now("clear_over_load", 4'd0, 1'b1, 1'b1);
        clear = 1'b1;
        expect_now("load_after_clear", 4'd4, 1'b0, 1'b0);
        bus.enab = 1'b0;
        tick();
        bus.load = 1'b1;
        expect_now("load_released", 4'd4, 1'b0, 1'b0);
        bus.enab = 1'b1;
        tick();
        expect_now("count_from_load", 4'd3, 1'b0, 1'b0);

        #5;
        check("scoreboard_drained", scb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the bench always ends on its own.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mod6_down_counter.md
Name: mod6_down_counter

Overview:
- Modulo-6 BCD down-counter (digit values 5..0) for the tens-of-seconds digit of the minutes/seconds timer in the microwave controller.
- Supports asynchronous active-low clear, asynchronous active-low parallel load, and a count enable.
- Provides a terminal-count output (`tc_saida`) for cascading into the next timer digit, plus a zero flag.

Parameters:
- WIDTH, 4, width of the loaded value and of the count output.
- MAX_VAL, 5, value the counter wraps to after 0 (modulus minus 1).

Ports:
- clk  input  1  single clock; counter advances on the rising edge.
- clear  input  1  asynchronous active-low reset; count forced to 0.
- load  input  1  asynchronous active-low parallel load of numero.
- enab  input  1  count enable, active-high, sampled on the rising clk edge.
- numero  input  WIDTH  parallel load value.
- numero_saida  output  WIDTH  current count, 0..5.
- tc_saida  output  1  terminal count: high when enab=1 and count=0.
- zero_saida  output  1  high when count=0.

Behaviour:
- Priority, highest first: clear=0, then load=0, then enabled count, then hold.
- clear=0: count becomes 0 immediately, with no clock needed. It is held at 0 while clear is low.
  - Reset values: numero_saida=0, zero_saida=1, tc_saida=enab.
- load=0 (clear=1): count takes numero immediately (level-sensitive, asynchronous) and follows numero while load is low.
  - If numero > 5, the loaded value is saturated to 5. The count is never outside 0..5.
- Counting: on a clk rising edge with clear=1, load=1 and enab=1, the count decrements by 1.
  - Wrap-around: 0 -> 5 on the same edge.
- Hold: with enab=0, the count is held across clock edges.
- numero is ignored while load=1.
- Outputs are combinational from the count register and enab; there is no added latency.
  - tc_saida = enab AND (count==0). It lasts one cycle per wrap when enab is continuously high, so the next digit decrements on that same edge.
  - zero_saida = (count==0), independent of enab.
- Simultaneous events:
  - clear and load both low: clear wins, count=0.
  - load released at a clock edge: the edge uses the loaded value as the starting point.
  - clear deasserted mid-operation: counting resumes from 0 on the next enabled edge, with the next count 5.
- No internal state other than the count register.

Decomposition:
- Shared timer package holds:
  - MOD6_MAX = 4'd5, the zero constant, and the digit WIDTH = 4.
  - These are reused by the mod-10 seconds counter and the minutes counter.
- No sub-module is needed: a single register plus next-state and output logic.
- An optional saturating load-value function lives in the package so the other counters can share the same clamp pattern.

Test Plan:
1. Clear, then count: pulse clear=0 then release; enab=1 for 7 rising edges.
   - Required sequence: 0 -> 5,4,3,2,1,0,5.
   - zero_saida=1 and tc_saida=1 exactly when the count is 0.
2. Async clear mid-count: with the count at 3, drive clear=0 with clk idle.
   - Count goes to 0 immediately; zero_saida=1.
3. Async load plus tc: load=0 with numero=3 and no clock edge -> numero_saida=3 immediately.
   - Release load, enab=1, clock 3 edges -> 2,1,0. At 0, tc_saida=1.
   - Changing numero to 4 while load=1 has no effect.
4. Enable gating: at count 0, set enab=0 and clock 2 edges.
   - Count stays 0; tc_saida=0; zero_saida=1.
5. Out-of-range load: load=0 with numero=9 -> count=5.
   - One enabled edge -> 4.
6. Priority: clear=0 and load=0 with numero=4 together -> count=0.
   - Release clear only -> count=4 immediately.
